mux_scan_controller: RTL and testbench
======================================

MUX_SCAN_CONTROLLER -- requirements
Module: mux_scan_controller

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1: cycles sel is held stable before mux_y is sampled; legal range 1..15.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port start  input  1  scan request; sampled on the rising edge of clk.
REQ-005 Port mask  input  8  channel enable; bit i set = channel i is scanned.
REQ-006 Port mux_y  input  1  output of the downstream 8:1 channel mux.
REQ-007 Port sel  output  3  channel select driven into the 8:1 mux.
REQ-008 Port busy  output  1  high while a scan is in progress.
REQ-009 Port done  output  1  one-cycle pulse marking scan completion.
REQ-010 Port result  output  8  sampled channel values; bit i = mux_y captured with sel=i.

Function
REQ-011 The block SHALL implement the FSM states IDLE, SETTLE, SAMPLE and DONE.
REQ-012 IDLE: busy=0 and done=0; sel and result SHALL hold their last values.
REQ-013 IDLE with start=1 at an edge (accept edge E0): the block SHALL latch mask into an internal mask_q, clear result to 0x00 and select the lowest set bit of mask as sel.
REQ-014 If mask==0x00 at E0, the block SHALL go directly to DONE; sel is unchanged and result=0x00.
REQ-015 Otherwise the block SHALL enter SETTLE with sel at the lowest set channel.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles with sel constant, then transition to SAMPLE.
REQ-017 SAMPLE SHALL last 1 cycle; at its closing edge result[sel] <= mux_y.
REQ-018 After SAMPLE, sel SHALL advance to the next higher set bit of mask_q and return to SETTLE; if no higher set bit exists, the FSM SHALL go to DONE.
REQ-019 Channels are scanned in ascending index order with no wrap-around; each enabled channel is sampled exactly once per scan.
REQ-020 DONE: done=1 and busy=0 for exactly 1 cycle, then unconditional return to IDLE.
REQ-021 busy SHALL be 1 in SETTLE and SAMPLE only.
REQ-022 Latency: with k set bits in mask, done SHALL be high in the cycle following edge E0 + k*(SETTLE_CYCLES+1); for k=0 this is the cycle following E0.
REQ-023 start asserted in SETTLE, SAMPLE or DONE SHALL be ignored and is not queued.
REQ-024 Changes on mask after E0 SHALL have no effect on the scan in progress.
REQ-025 result bits of disabled channels SHALL read 0.
REQ-026 result SHALL be stable from DONE until the next accept edge.
REQ-027 sel SHALL change only on the edge entering SETTLE, so it is glitch-free relative to the sample point.

Reset
REQ-028 While rst=1, the outputs SHALL immediately, without waiting for clk, be: state=IDLE, sel=3'b000, busy=0, done=0, result=0x00, mask_q=0x00.
REQ-029 rst asserted mid-scan SHALL abort the scan with no done pulse.
REQ-030 The first edge after rst deasserts SHALL be able to accept a start.

Verification (SETTLE_CYCLES=1 unless stated; bench drives a real 8:1 mux with data in[7:0])
REQ-031 in=0xA5, mask=0xFF, start pulse -> sel steps 0..7, each for 2 cycles; done at E0+16; result=0xA5.
REQ-032 in=0xFF, mask=0x81 -> sel visits 0 then 7 only; done at E0+4; result=0x81.
REQ-033 mask=0x00 -> done in the cycle after E0; busy never high; result=0x00.
REQ-034 Re-pulse start and toggle mask to 0x0F mid-scan of mask=0xF0 -> scan unaffected; exactly one done pulse; result[3:0]=0.
REQ-035 rst pulse during SETTLE on channel 3 -> sel=0, busy=0, result=0x00 asynchronously; no done; a following start with mask=0x01 and in=0x01 gives result=0x01.
REQ-036 SETTLE_CYCLES=3, mask=0x10, in=0x10 -> sel=4 held 4 cycles; done at E0+4; result=0x10.

Source files
------------

// File: rtl/mux_scan_controller.sv
// Scans the enabled channels of an external 8:1 mux in ascending order, holding
// each select for SETTLE_CYCLES cycles before capturing mux_y into result.
module mux_scan_controller #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] mask,
    input  logic       mux_y,
    output logic [2:0] sel,
    output logic       busy,
    output logic       done,
    output logic [7:0] result
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0] r_state;
    logic [7:0] r_mask_q;
    logic [7:0] r_result;
    logic [2:0] r_sel;
    logic [3:0] r_cnt;

    logic [2:0] w_first_sel;
    logic [2:0] w_next_sel;
    logic       w_next_valid;

    // Descending loops so the last match wins, i.e. the lowest qualifying bit.
    always_comb begin
        w_first_sel  = 3'd0;
        w_next_sel   = 3'd0;
        w_next_valid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                w_first_sel = 3'(i);
            end
            if (r_mask_q[i] && (3'(i) > r_sel)) begin
                w_next_sel   = 3'(i);
                w_next_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mask_q <= 8'h00;
            r_result <= 8'h00;
            r_sel    <= 3'd0;
            r_cnt    <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mask_q <= mask;
                        r_result <= 8'h00;
                        r_cnt    <= 4'd0;
                        if (mask == 8'h00) begin
                            r_state <= S_DONE;
                        end else begin
                            r_sel   <= w_first_sel;
                            r_state <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == 4'(SETTLE_CYCLES - 1)) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    r_result[r_sel] <= mux_y;
                    if (w_next_valid) begin
                        // sel only moves on the edge that re-enters SETTLE.
                        r_sel   <= w_next_sel;
                        r_cnt   <= 4'd0;
                        r_state <= S_SETTLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign sel    = r_sel;
    assign result = r_result;
    assign busy   = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    assign done   = (r_state == S_DONE);

endmodule

// File: tb/tb_mux_scan_controller.sv
// Bench for mux_scan_controller: two instances (SETTLE_CYCLES 1 and 3) each
// driving a modelled 8:1 mux; expected results and sel traces are queued per scan.
module tb_mux_scan_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0;
    logic       start3 = 1'b0;
    logic [7:0] mask = 8'h00;
    logic [7:0] in_data = 8'h00;

    logic [2:0] sel1, sel3;
    logic       busy1, busy3, done1, done3;
    logic [7:0] result1, result3;
    logic       mux_y1, mux_y3;

    logic       use3 = 1'b0;
    logic [2:0] cur_sel;
    logic       cur_busy, cur_done;
    logic [7:0] cur_result;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    int         lat_q[$];
    logic [2:0] sel_q[$];

    always #5 clk = ~clk;

    assign mux_y1 = in_data[sel1];
    assign mux_y3 = in_data[sel3];

    assign cur_sel    = use3 ? sel3    : sel1;
    assign cur_busy   = use3 ? busy3   : busy1;
    assign cur_done   = use3 ? done3   : done1;
    assign cur_result = use3 ? result3 : result1;

    mux_scan_controller #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .mask(mask), .mux_y(mux_y1),
        .sel(sel1), .busy(busy1), .done(done1), .result(result1)
    );

    mux_scan_controller #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .mask(mask), .mux_y(mux_y3),
        .sel(sel3), .busy(busy3), .done(done3), .result(result3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One scan: push expectations, pulse start, follow sel while busy, then check
    // latency, result, done width and result hold. disturb re-pulses start and
    // changes mask while the scan is running.
    task automatic run_scan(input bit i3, input logic [7:0] din, input logic [7:0] m, input bit disturb);
        int s;
        int n;
        bit seen;
        int exp_lat;
        logic [7:0] exp_res;
        s = i3 ? 3 : 1;
        exp_q.push_back(din & m);
        lat_q.push_back($countones(m) * (s + 1) + 1);
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                repeat (s + 1) sel_q.push_back(3'(i));
            end
        end
        @(negedge clk);
        use3    = i3;
        in_data = din;
        mask    = m;
        if (i3) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        n = 1;
        seen = 1'b0;
        while (!seen && n < 200) begin
            if (disturb && n == 3) begin
                start1 = 1'b1;
                mask   = 8'h0F;
            end
            if (disturb && n == 5) start1 = 1'b0;
            if (cur_done) begin
                seen = 1'b1;
            end else begin
                if (sel_q.size() > 0) check("busy_during_scan", 32'(cur_busy), 32'd1);
                else                  check("busy_overrun", 32'(cur_busy), 32'd0);
                if (cur_busy && sel_q.size() > 0) check("sel_trace", 32'(cur_sel), 32'(sel_q.pop_front()));
                @(negedge clk);
                n++;
            end
        end
        exp_lat = lat_q.pop_front();
        exp_res = exp_q.pop_front();
        check("done_latency", 32'(n), 32'(exp_lat));
        check("sel_trace_left", 32'(sel_q.size()), 32'd0);
        sel_q.delete();
        check("result", 32'(cur_result), 32'(exp_res));
        check("busy_at_done", 32'(cur_busy), 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("done_after", 32'(cur_done), 32'd0);
        end
        check("result_hold", 32'(cur_result), 32'(exp_res));
        $display("scan s=%0d in=0x%02h mask=0x%02h: result=0x%02h latency=%0d", s, din, m, cur_result, n);
    endtask

    initial begin
        #3;
        check("rst_sel",    32'(sel1),    32'd0);
        check("rst_busy",   32'(busy1),   32'd0);
        check("rst_done",   32'(done1),   32'd0);
        check("rst_result", 32'(result1), 32'd0);
        check("rst_sel3",   32'(sel3),    32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_scan(1'b0, 8'hA5, 8'hFF, 1'b0);
        run_scan(1'b0, 8'hFF, 8'h81, 1'b0);
        run_scan(1'b0, 8'hFF, 8'h00, 1'b0);
        run_scan(1'b0, 8'hFF, 8'hF0, 1'b1);

        // Abort a scan while settling on channel 3 after channel 2 was captured.
        @(negedge clk);
        use3 = 1'b0;
        in_data = 8'hFF;
        mask = 8'h0C;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_sel",    32'(sel1),    32'd3);
        check("pre_rst_busy",   32'(busy1),   32'd1);
        check("pre_rst_result", 32'(result1), 32'h04);
        #2 rst = 1'b1;
        #1;
        check("async_rst_sel",    32'(sel1),    32'd0);
        check("async_rst_busy",   32'(busy1),   32'd0);
        check("async_rst_result", 32'(result1), 32'h00);
        check("async_rst_done",   32'(done1),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("no_done_after_abort", 32'(done1), 32'd0);
        end
        $display("abort: sel=%0d busy=%0d result=0x%02h", sel1, busy1, result1);

        run_scan(1'b0, 8'h01, 8'h01, 1'b0);
        run_scan(1'b1, 8'h10, 8'h10, 1'b0);
        run_scan(1'b1, 8'h5A, 8'h3C, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
